// File: rtl/ca_code_acquire.sv
// ----------------------------------------------------------------------------
// ca_code_acquire
//
// GPS C/A code acquisition. It correlates a 1-bit hard-decision chip stream
// against a locally generated Gold code for the selected PRN. The local code
// phase slips by one chip per failed 1023-chip dwell until |correlation|
// reaches THRESH. After lock it keeps running the replica and flags each
// code epoch.
//
// Optional build macro: CA_ACQ_PEAK_SEARCH_EN
//   undefined : first phase whose |correlation| reaches THRESH wins.
//   defined   : all 1023 phases are evaluated. The strongest phase (earliest
//               on ties) is re-acquired by slipping back to it.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous, active-high reset
//   prn_num    in   [5:0] SV PRN 1..37, sampled on start
//   start      in   one-cycle pulse, (re)starts an acquisition
//   rx_valid   in   qualifies rx_chip
//   rx_chip    in   received hard-decision chip
//   busy       out  acquisition in progress (DWELL or SLIP)
//   locked     out  code lock achieved
//   fail       out  no lock found, or invalid PRN
//   code_phase out  [9:0] number of slips applied
//   corr_peak  out  [9:0] |accumulator| of the deciding dwell
//   corr_sign  out  deciding accumulator was negative (inverted stream)
//   epoch      out  one-cycle pulse per local code epoch while locked
// ----------------------------------------------------------------------------
module ca_code_acquire #(
  parameter int THRESH = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] prn_num,
  input  logic       start,
  input  logic       rx_valid,
  input  logic       rx_chip,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic [9:0] code_phase,
  output logic [9:0] corr_peak,
  output logic       corr_sign,
  output logic       epoch
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DWELL  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  localparam logic [10:0] THRESH_MAG = 11'(THRESH);

  // G2 phase-selector taps {a, b} for each PRN
  function automatic logic [7:0] g2_taps(input logic [5:0] prn);
    logic [7:0] taps;
    case (prn)
      6'd1:    taps = {4'd2, 4'd6};
      6'd2:    taps = {4'd3, 4'd7};
      6'd3:    taps = {4'd4, 4'd8};
      6'd4:    taps = {4'd5, 4'd9};
      6'd5:    taps = {4'd1, 4'd9};
      6'd6:    taps = {4'd2, 4'd10};
      6'd7:    taps = {4'd1, 4'd8};
      6'd8:    taps = {4'd2, 4'd9};
      6'd9:    taps = {4'd3, 4'd10};
      6'd10:   taps = {4'd2, 4'd3};
      6'd11:   taps = {4'd3, 4'd4};
      6'd12:   taps = {4'd5, 4'd6};
      6'd13:   taps = {4'd6, 4'd7};
      6'd14:   taps = {4'd7, 4'd8};
      6'd15:   taps = {4'd8, 4'd9};
      6'd16:   taps = {4'd9, 4'd10};
      6'd17:   taps = {4'd1, 4'd4};
      6'd18:   taps = {4'd2, 4'd5};
      6'd19:   taps = {4'd3, 4'd6};
      6'd20:   taps = {4'd4, 4'd7};
      6'd21:   taps = {4'd5, 4'd8};
      6'd22:   taps = {4'd6, 4'd9};
      6'd23:   taps = {4'd1, 4'd3};
      6'd24:   taps = {4'd4, 4'd6};
      6'd25:   taps = {4'd5, 4'd7};
      6'd26:   taps = {4'd6, 4'd8};
      6'd27:   taps = {4'd7, 4'd9};
      6'd28:   taps = {4'd8, 4'd10};
      6'd29:   taps = {4'd1, 4'd6};
      6'd30:   taps = {4'd2, 4'd7};
      6'd31:   taps = {4'd3, 4'd8};
      6'd32:   taps = {4'd4, 4'd9};
      6'd33:   taps = {4'd5, 4'd10};
      6'd34:   taps = {4'd4, 4'd10};
      6'd35:   taps = {4'd1, 4'd7};
      6'd36:   taps = {4'd2, 4'd8};
      6'd37:   taps = {4'd4, 4'd10};
      // Only valid PRNs are ever latched; equal taps cancel to a plain G1 code.
      default: taps = {4'd1, 4'd1};
    endcase
    return taps;
  endfunction

  state_t            state_r;
  logic [5:0]        prn_r;
  logic [10:1]       g1_r;
  logic [10:1]       g2_r;
  logic signed [10:0] acc_r;
  logic [9:0]        chip_cnt_r;

  logic [7:0]        taps_s;
  logic              local_chip_s;
  logic [10:1]       g1_next_s;
  logic [10:1]       g2_next_s;
  logic signed [10:0] acc_next_s;
  logic [10:0]       mag_s;
  logic              prn_ok_s;
  logic              last_chip_s;

`ifdef CA_ACQ_PEAK_SEARCH_EN
  logic [10:0]       best_mag_r;
  logic [9:0]        best_phase_r;
  logic              best_sign_r;
  logic              reslip_r;
  logic [9:0]        reslip_cnt_r;
  logic [10:0]       fin_mag_s;
  logic [9:0]        fin_phase_s;
  logic              fin_sign_s;
`endif

  // Local replica, next accumulator value and dwell-end magnitude
  always_comb begin
    taps_s       = g2_taps(prn_r);
    local_chip_s = g1_r[10] ^ g2_r[taps_s[7:4]] ^ g2_r[taps_s[3:0]];
    g1_next_s    = {g1_r[9:1], g1_r[3] ^ g1_r[10]};
    g2_next_s    = {g2_r[9:1], g2_r[2] ^ g2_r[3] ^ g2_r[6] ^ g2_r[8] ^ g2_r[9] ^ g2_r[10]};
    if (rx_chip == local_chip_s) begin
      acc_next_s = acc_r + 11'sd1;
    end else begin
      acc_next_s = acc_r - 11'sd1;
    end
    if (acc_next_s[10]) begin
      mag_s = $unsigned(-acc_next_s);
    end else begin
      mag_s = $unsigned(acc_next_s);
    end
    prn_ok_s    = (prn_num >= 6'd1) && (prn_num <= 6'd37);
    last_chip_s = (chip_cnt_r == 10'd1022);
`ifdef CA_ACQ_PEAK_SEARCH_EN
    // Strict greater-than keeps the earliest phase on ties
    if (mag_s > best_mag_r) begin
      fin_mag_s   = mag_s;
      fin_phase_s = code_phase;
      fin_sign_s  = acc_next_s[10];
    end else begin
      fin_mag_s   = best_mag_r;
      fin_phase_s = best_phase_r;
      fin_sign_s  = best_sign_r;
    end
`endif
  end

  // Acquisition FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      prn_r      <= 6'd0;
      g1_r       <= 10'h3FF;
      g2_r       <= 10'h3FF;
      acc_r      <= 11'sd0;
      chip_cnt_r <= 10'd0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      code_phase <= 10'd0;
      corr_peak  <= 10'd0;
      corr_sign  <= 1'b0;
      epoch      <= 1'b0;
`ifdef CA_ACQ_PEAK_SEARCH_EN
      best_mag_r   <= 11'd0;
      best_phase_r <= 10'd0;
      best_sign_r  <= 1'b0;
      reslip_r     <= 1'b0;
      reslip_cnt_r <= 10'd0;
`endif
    end else begin
      epoch <= 1'b0;
      if (start) begin
        code_phase <= 10'd0;
        locked     <= 1'b0;
`ifdef CA_ACQ_PEAK_SEARCH_EN
        best_mag_r   <= 11'd0;
        best_phase_r <= 10'd0;
        best_sign_r  <= 1'b0;
        reslip_r     <= 1'b0;
        reslip_cnt_r <= 10'd0;
`endif
        if (prn_ok_s) begin
          prn_r      <= prn_num;
          g1_r       <= 10'h3FF;
          g2_r       <= 10'h3FF;
          acc_r      <= 11'sd0;
          chip_cnt_r <= 10'd0;
          fail       <= 1'b0;
          corr_peak  <= 10'd0;
          corr_sign  <= 1'b0;
          busy       <= 1'b1;
          state_r    <= ST_DWELL;
        end else begin
          fail    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_FAIL;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_DWELL: begin
            if (rx_valid) begin
              acc_r <= acc_next_s;
              g1_r  <= g1_next_s;
              g2_r  <= g2_next_s;
              if (last_chip_s) begin
                // Decision uses the accumulator including this chip
                chip_cnt_r <= 10'd0;
`ifdef CA_ACQ_PEAK_SEARCH_EN
                if (code_phase == 10'd1022) begin
                  if (fin_mag_s >= THRESH_MAG) begin
                    code_phase <= fin_phase_s;
                    corr_peak  <= fin_mag_s[9:0];
                    corr_sign  <= fin_sign_s;
                    g1_r       <= 10'h3FF;
                    g2_r       <= 10'h3FF;
                    acc_r      <= 11'sd0;
                    // Replica now trails by 1022 chips; hold phase+1 chips
                    // (mod 1023) to land on the best phase.
                    if (fin_phase_s == 10'd1022) begin
                      locked  <= 1'b1;
                      busy    <= 1'b0;
                      state_r <= ST_LOCKED;
                    end else begin
                      reslip_r     <= 1'b1;
                      reslip_cnt_r <= fin_phase_s + 10'd1;
                      state_r      <= ST_SLIP;
                    end
                  end else begin
                    fail    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_FAIL;
                  end
                end else begin
                  best_mag_r   <= fin_mag_s;
                  best_phase_r <= fin_phase_s;
                  best_sign_r  <= fin_sign_s;
                  state_r      <= ST_SLIP;
                end
`else
                corr_peak <= mag_s[9:0];
                corr_sign <= acc_next_s[10];
                if (mag_s >= THRESH_MAG) begin
                  locked  <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= ST_LOCKED;
                end else if (code_phase == 10'd1022) begin
                  fail    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= ST_FAIL;
                end else begin
                  state_r <= ST_SLIP;
                end
`endif
              end else begin
                chip_cnt_r <= chip_cnt_r + 10'd1;
              end
            end
          end
          ST_SLIP: begin
            // Consume one chip with the replica held: delays it by one chip
            if (rx_valid) begin
`ifdef CA_ACQ_PEAK_SEARCH_EN
              if (reslip_r) begin
                if (reslip_cnt_r == 10'd1) begin
                  reslip_r     <= 1'b0;
                  reslip_cnt_r <= 10'd0;
                  locked       <= 1'b1;
                  busy         <= 1'b0;
                  state_r      <= ST_LOCKED;
                end else begin
                  reslip_cnt_r <= reslip_cnt_r - 10'd1;
                end
              end else begin
                code_phase <= code_phase + 10'd1;
                acc_r      <= 11'sd0;
                chip_cnt_r <= 10'd0;
                state_r    <= ST_DWELL;
              end
`else
              code_phase <= code_phase + 10'd1;
              acc_r      <= 11'sd0;
              chip_cnt_r <= 10'd0;
              state_r    <= ST_DWELL;
`endif
            end
          end
          ST_LOCKED: begin
            if (rx_valid) begin
              g1_r <= g1_next_s;
              g2_r <= g2_next_s;
              if (last_chip_s) begin
                chip_cnt_r <= 10'd0;
                epoch      <= 1'b1;
              end else begin
                chip_cnt_r <= chip_cnt_r + 10'd1;
              end
            end
          end
          ST_FAIL: begin
            state_r <= ST_FAIL;
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            locked  <= 1'b0;
            fail    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ca_code_acquire.md
Name: ca_code_acquire

Overview:
Receive-side counterpart of the CA code generator. It accepts a 1-bit hard-decision chip stream and correlates it against a locally generated Gold code for the selected PRN. It slips the local code phase one chip at a time until the correlation magnitude over one full 1023-chip epoch reaches a threshold. Once locked, it tracks code epochs. It sits between the GPS front-end sample strobe logic and the navigation-bit / tracking logic.

Parameters:
THRESH, 512, lock threshold on |correlation| over 1023 chips; legal range 66..1023, above the Gold cross-correlation bound of 65.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
prn_num  in  6  SV PRN, valid 1..37; sampled on start
start  in  1  one-cycle pulse; begins a new acquisition, and restarts one if busy
rx_valid  in  1  qualifies rx_chip; back-to-back allowed
rx_chip  in  1  received chip
busy  out  1  high in DWELL or SLIP
locked  out  1  high in LOCKED
fail  out  1  high in FAIL
code_phase  out  10  number of slips applied, 0..1022
corr_peak  out  10  |accumulator| of the deciding dwell
corr_sign  out  1  1 = locked on an inverted sequence (accumulator negative)
epoch  out  1  one-cycle pulse in LOCKED when the local chip counter wraps 1022->0

Behaviour:
- Reset: state IDLE; all outputs 0; G1 and G2 = all ones; accumulator, chip_cnt and slip count = 0.
- Local code generation:
  - G1 feedback = g1[3]^g1[10].
  - G2 feedback = g2[2]^g2[3]^g2[6]^g2[8]^g2[9]^g2[10].
  - Both registers shift toward bit 10.
  - local_chip = g1[10]^g2[a]^g2[b], combinational from the current state.
  - G2 taps (a,b) per PRN, IS-GPS-200: 1:2,6 2:3,7 3:4,8 4:5,9 5:1,9 6:2,10 7:1,8 8:2,9 9:3,10 10:2,3 11:3,4 12:5,6 13:6,7 14:7,8 15:8,9 16:9,10 17:1,4 18:2,5 19:3,6 20:4,7 21:5,8 22:6,9 23:1,3 24:4,6 25:5,7 26:6,8 27:7,9 28:8,10 29:1,6 30:2,7 31:3,8 32:4,9 33:5,10 34:4,10 35:1,7 36:2,8 37:4,10.
- States: IDLE, DWELL, SLIP, LOCKED, FAIL.
- start with a valid PRN, from any state:
  - Latch prn_num; G1/G2 = all ones; accumulator = 0; chip_cnt = 0; code_phase = 0.
  - Clear locked, fail, corr_peak and corr_sign.
  - Next state DWELL.
- start with an invalid PRN (0 or 38..63): next state FAIL; code_phase = 0.
- DWELL, on each rx_valid:
  - Accumulator += +1 if rx_chip==local_chip, else −1. The accumulator is 11-bit signed, range −1023..+1023, and never overflows.
  - LFSRs advance; chip_cnt increments.
- Dwell decision, on the 1023rd rx_valid of a dwell:
  - The decision uses the accumulator value including this chip, on the same edge; no chips are dropped.
  - corr_peak and corr_sign are updated.
  - If |acc| >= THRESH: go to LOCKED.
  - Else if code_phase == 1022: go to FAIL.
  - Else: go to SLIP.
- SLIP:
  - The next rx_valid is consumed with the LFSRs held and no accumulation. This delays the local replica by one chip.
  - code_phase increments; accumulator and chip_cnt clear; return to DWELL.
- LOCKED:
  - The LFSRs and chip_cnt continue to advance on each rx_valid.
  - epoch pulses on the edge where chip_cnt wraps 1022->0.
  - No further slips. The block stays in LOCKED until start or rst.
- FAIL: holds until start or rst.
- Arbitration and idle behaviour:
  - rst has priority over start; start has priority over rx_valid in the same cycle.
  - rx_valid in IDLE or FAIL is ignored.
- Reset during any state returns to the reset values on the next edge.
- Lock-time relation: with received code delayed by k chips (k = 0..1022), lock occurs at code_phase = k, after (k+1)·1023 + k rx_valid strobes.

Optional Feature:
CA_ACQ_PEAK_SEARCH_EN
- Defined:
  - A dwell is never terminated by a threshold crossing.
  - All 1023 phases are evaluated. The block tracks the maximum |acc| and its phase, and updates only on a strict greater-than, so the earliest phase wins ties.
  - After phase 1022 completes:
    - If max >= THRESH: code_phase, corr_peak and corr_sign are set from the best phase. The LFSRs are re-initialised and the block re-slips to that phase via SLIP cycles before entering LOCKED.
    - Else: FAIL.
- Undefined: first-crossing behaviour as above.

Test Plan:
1. PRN 1, rx = reference generator stream aligned from chip 0, rx_valid every cycle -> locked after 1023 strobes; code_phase=0, corr_peak=1023, corr_sign=0; epoch pulses every 1023 strobes thereafter.
2. PRN 1, rx stream started at chip 1018 (5-chip delay) -> locked with code_phase=5 after 6·1023+5 strobes; corr_peak=1023.
3. PRN 7, rx = inverted aligned stream, rx_valid every 3rd cycle -> locked; corr_sign=1, corr_peak=1023, code_phase=0.
4. PRN 3 selected, rx = PRN 9 stream -> every dwell |acc| <= 65 -> fail=1 after 1023 dwells; busy=0.
5. start with prn_num=0, then separately 38 -> fail=1 the next cycle, code_phase=0; a start with PRN 2 then recovers to DWELL.
6. rst asserted mid-DWELL at chip 500, and start re-pulsed mid-SLIP -> rst returns all outputs to 0 and IDLE on the next edge; the restart yields code_phase=0, a cleared accumulator, and a correct subsequent lock.
